// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64M shift-add multiply / restoring divide unit
// W-form operations are compiled in when MULDIV_WORD_OPS_EN is defined.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(XLEN + 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, last_cnt;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, a_ext_q, result_q, result_d;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              word_q, neg_quo_q, neg_rem_q, divz_q, ovf_q;

  logic              accept, is_div, sgn_a, sgn_b, neg_a, neg_b, word_sel;
  logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, div_a, min_val;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin;

  assign accept = start && (state_q != S_RUN);
  assign is_div = funct3[2];
  assign sgn_a  = is_div ? ~funct3[0] : (funct3[1] ^ funct3[0]);
  assign sgn_b  = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);

`ifdef MULDIV_WORD_OPS_EN
  assign word_sel = word;
`else
  logic unused_word;
  assign unused_word = word;
  assign word_sel    = 1'b0;
`endif

  always_comb begin
    ext_a   = operand_a;
    ext_b   = operand_b;
    min_val = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_WORD_OPS_EN
    if (word_sel) begin
      ext_a   = {{(XLEN-32){sgn_a & operand_a[31]}}, operand_a[31:0]};
      ext_b   = {{(XLEN-32){sgn_b & operand_b[31]}}, operand_b[31:0]};
      min_val = {{(XLEN-31){1'b1}}, 31'd0};
    end
`endif
  end

  assign neg_a = sgn_a & ext_a[XLEN-1];
  assign neg_b = sgn_b & ext_b[XLEN-1];
  assign mag_a = neg_a ? -ext_a : ext_a;
  assign mag_b = neg_b ? -ext_b : ext_b;

  // A word dividend is pre-shifted to the top so 32 iterations consume all of it.
`ifdef MULDIV_WORD_OPS_EN
  assign div_a    = word_sel ? (mag_a << (XLEN - 32)) : mag_a;
`else
  assign div_a    = mag_a;
`endif
  assign last_cnt = word_q ? CW'(32) : CW'(XLEN);

  // acc_q holds {product high, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  always_comb begin
    prod_s = neg_quo_q ? -acc_q : acc_q;
    quo_s  = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (divz_q) begin
      quo_s = '1;
      rem_s = a_ext_q;
    end else if (ovf_q) begin
      quo_s = a_ext_q;
      rem_s = '0;
    end
    if (op_q[2])                 fin = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'b00) fin = prod_s[XLEN-1:0];
    else                         fin = prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_WORD_OPS_EN
    if (word_q) begin
      if (op_q[2])                 fin = {{(XLEN-32){fin[31]}}, fin[31:0]};
      else if (op_q[1:0] == 2'b00) fin = {{(XLEN-32){acc_q[XLEN-1]}}, acc_q[XLEN-32 +: 32]};
      else                         fin = '0;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = {{XLEN{1'b0}}, (is_div ? div_a : mag_b)};
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        // One extra RUN cycle after the last iteration applies sign/special-case fixups.
        if (cnt_q == last_cnt) begin
          state_d  = S_DONE;
          result_d = fin;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      mcand_q   <= '0;
      a_ext_q   <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      word_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      if (accept) begin
        mcand_q   <= is_div ? mag_b : mag_a;
        a_ext_q   <= ext_a;
        op_q      <= funct3;
        rd_q      <= rd_in;
        word_q    <= word_sel;
        neg_quo_q <= neg_a ^ neg_b;
        neg_rem_q <= neg_a;
        divz_q    <= (ext_b == '0);
        ovf_q     <= is_div & sgn_a & (ext_a == min_val) & (ext_b == '1);
      end
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
// Word-op sequences are included when MULDIV_WORD_OPS_EN is defined.
module tb_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, word = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] operand_a = 64'd0, operand_b = 64'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
  } vec_t;
  vec_t vt[24];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .word(word),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, pr;
    logic [127:0] ua, ub, pu;
    logic ovf;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    ovf = (a == MINV) && (b == ONES);
    case (f3)
      3'd0: begin pu = ua * ub; return pu[63:0]; end
      3'd1: begin pr = sa * sb; return pr[127:64]; end
      3'd2: begin pr = sa * $signed(ub); return pr[127:64]; end
      3'd3: begin pu = ua * ub; return pu[127:64]; end
      3'd4: return (b == 0) ? ONES : ovf ? MINV : 64'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: return (b == 0) ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic start_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] r, input logic wd, input logic [63:0] exp, input bit hold);
    exp_t e;
    @(negedge clk);
    funct3 = f3; operand_a = a; operand_b = b; rd_in = r; word = wd; start = 1'b1;
    e.res = exp; e.rd = r;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int lat, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done_after_%0d", name, lat);
    end else if (cyc - acc_cyc != lat) begin
      failures++;
      $display("FAIL %s_latency actual=%0d expected=%0d", name, cyc - acc_cyc, lat);
    end
  endtask

  task automatic quiet(input int ncyc, input string name);
    int nd = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk(name, 64'(nd), 64'd0);
  endtask

  // Scoreboard monitor: every done pops one expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("busy_done_exclusive", 64'(busy & done), 64'd0);
        if (done) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done expected=no_pending_op");
          end else begin
            e = sbq.pop_front();
            chk("result", result, e.res);
            chk("rd_out", 64'(rd_out), 64'(e.rd));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB};
    vt[1]  = '{3'd3, ONES, ONES, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vt[2]  = '{3'd1, ONES, ONES, 5'd3, 64'd0};
    vt[3]  = '{3'd2, ONES, ONES, 5'd4, ONES};
    vt[4]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD};
    vt[5]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, ONES};
    vt[6]  = '{3'd4, MINV, ONES, 5'd7, MINV};
    vt[7]  = '{3'd6, MINV, ONES, 5'd8, 64'd0};
    vt[8]  = '{3'd5, 64'd5, 64'd0, 5'd9, ONES};
    vt[9]  = '{3'd7, 64'd5, 64'd0, 5'd10, 64'd5};
    vt[10] = '{3'd4, 64'd5, 64'd0, 5'd0, ONES};
    vt[11] = '{3'd6, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd11, 64'hFFFF_FFFF_FFFF_FFFB};
    vt[12] = '{3'd5, 64'd100, 64'd7, 5'd31, 64'd14};
    vt[13] = '{3'd7, 64'd100, 64'd7, 5'd12, 64'd2};
    vt[14] = '{3'd0, 64'h1_0000_0001, 64'h1_0000_0001, 5'd13, 64'h2_0000_0001};
    vt[15] = '{3'd3, 64'h1_0000_0001, 64'h1_0000_0001, 5'd14, 64'd1};
    vt[16] = '{3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd15, 64'hFFFF_FFFF_FFFF_FFFD};
    vt[17] = '{3'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd16, 64'd1};
    vt[18] = '{3'd3, MINV, MINV, 5'd17, 64'h4000_0000_0000_0000};
    vt[19] = '{3'd1, MINV, MINV, 5'd18, 64'h4000_0000_0000_0000};
    vt[20] = '{3'd2, MINV, 64'd2, 5'd19, ONES};
    vt[21] = '{3'd0, ONES, ONES, 5'd20, 64'd1};
    vt[22] = '{3'd5, ONES, 64'd1, 5'd21, ONES};
    vt[23] = '{3'd7, MINV, 64'd3, 5'd22, 64'd2};

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_rd_out", 64'(rd_out), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 24; i++) begin
      start_op(vt[i].f3, vt[i].a, vt[i].b, vt[i].rd, 1'b0, vt[i].exp, 1'b0);
      wait_done(65, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 12; i++) begin
      logic [2:0]  f3;
      logic [63:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 5) == 0) b = 64'd0;
      start_op(f3, a, b, 5'($urandom_range(0, 31)), 1'b0, model(f3, a, b), 1'b0);
      wait_done(65, $sformatf("rnd%0d", i));
    end

    // start pulsed and operands changed mid-run must not disturb the op in flight
    start_op(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    repeat (10) @(negedge clk);
    funct3 = 3'd5; operand_a = 64'd123; operand_b = 64'd4; rd_in = 5'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0; operand_a = 64'hDEAD;
    wait_done(65, "ignore_start");
    quiet(70, "ignore_no_extra_done");

    // start held through the done cycle: second op accepted with no gap
    start_op(3'd5, 64'd100, 64'd7, 5'd3, 1'b0, 64'd14, 1'b1);
    wait_done(65, "b2b_first");
    begin
      exp_t e;
      funct3 = 3'd7; rd_in = 5'd4;
      e.res = 64'd2; e.rd = 5'd4;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_done_low", 64'(done), 64'd0);
    start = 1'b0;
    wait_done(65, "b2b_second");

`ifdef MULDIV_WORD_OPS_EN
    start_op(3'd4, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    wait_done(33, "divw");
    start_op(3'd0, 64'hFFFF_FFFF_4000_0000, 64'd2, 5'd6, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    wait_done(33, "mulw");
    start_op(3'd1, ONES, ONES, 5'd7, 1'b1, 64'd0, 1'b0);
    wait_done(33, "word_mulh_zero");
    start_op(3'd5, 64'hFFFF_FFFF_0000_0064, 64'h1234_5678_0000_0007, 5'd8, 1'b1, 64'd14, 1'b0);
    wait_done(33, "divuw");
    word = 1'b0;
`endif

    // asynchronous reset mid-run
    start_op(3'd0, 64'd3, 64'd5, 5'd2, 1'b0, 64'd15, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_rd_out", 64'(rd_out), 64'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    quiet(80, "midrst_no_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
